// File: rtl/mem_lane_responder.sv
// Lane-granular memory responder: accepts one fill or writeback at a time and
// completes it exactly MEM_LATENCY cycles after acceptance with a one-cycle rdy_o pulse.
module mem_lane_responder #(
  parameter int MEM_LATENCY = 4,
  parameter int MEM_LANES   = 256,
  parameter int LANE_SIZE   = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rd_i,
  input  logic                 wr_i,
  input  logic [31:0]          addr_i,
  input  logic [LANE_SIZE-1:0] wr_data_i,
  output logic                 ready_o,
  output logic                 rdy_o,
  output logic [LANE_SIZE-1:0] rd_data_o
);

  localparam int         LANE_BITS = $clog2(MEM_LANES);
  localparam logic [7:0] CNT_LOAD  = 8'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_RD = 2'd1,
    BUSY_WR = 2'd2,
    RESP    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [LANE_BITS-1:0] lane_q, lane_d;
  logic [LANE_SIZE-1:0] wdata_q, wdata_d;
  logic                 ready_q, ready_d;
  logic                 rdy_q, rdy_d;
  logic [LANE_SIZE-1:0] rd_data_q, rd_data_d;
  logic [LANE_SIZE-1:0] mem_q [MEM_LANES];

  logic                 commit_wr_s, commit_rd_s;
  logic [LANE_BITS-1:0] req_lane_s, commit_lane_s;
  logic [LANE_SIZE-1:0] commit_data_s;
  logic                 unused_addr_s;

  assign req_lane_s    = addr_i[4 +: LANE_BITS];
  assign unused_addr_s = ^{addr_i[31:4+LANE_BITS], addr_i[3:0]};

  // Next-state, counter and commit decode; a single-cycle latency bypasses BUSY_*.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lane_d        = lane_q;
    wdata_d       = wdata_q;
    commit_wr_s   = 1'b0;
    commit_rd_s   = 1'b0;
    commit_lane_s = lane_q;
    commit_data_s = wdata_q;
    case (state_q)
      IDLE: begin
        if (wr_i || rd_i) begin
          lane_d = req_lane_s;
          cnt_d  = CNT_LOAD;
          if (wr_i) begin
            wdata_d = wr_data_i;
          end else begin
            wdata_d = wdata_q;
          end
          if (MEM_LATENCY == 1) begin
            state_d       = RESP;
            commit_wr_s   = wr_i;
            commit_rd_s   = ~wr_i;
            commit_lane_s = req_lane_s;
            commit_data_s = wr_data_i;
          end else begin
            state_d = wr_i ? BUSY_WR : BUSY_RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_RD, BUSY_WR: begin
        if (cnt_q <= 8'd1) begin
          state_d     = RESP;
          cnt_d       = 8'd0;
          commit_wr_s = (state_q == BUSY_WR);
          commit_rd_s = (state_q == BUSY_RD);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    ready_d   = (state_d == IDLE);
    rdy_d     = (state_d == RESP);
    rd_data_d = commit_rd_s ? mem_q[commit_lane_s] : rd_data_q;
  end

  // Control and output registers; reset aborts any in-flight request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      lane_q    <= '0;
      wdata_q   <= '0;
      ready_q   <= 1'b1;
      rdy_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lane_q    <= lane_d;
      wdata_q   <= wdata_d;
      ready_q   <= ready_d;
      rdy_q     <= rdy_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Lane storage is deliberately not reset; a write commits only on entry to RESP.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit_wr_s) begin
      mem_q[commit_lane_s] <= commit_data_s;
    end
  end

  assign ready_o   = ready_q;
  assign rdy_o     = rdy_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_mem_lane_responder.sv
// Directed and randomized checks of mem_lane_responder against a lane-array
// reference model; a second instance runs with MEM_LATENCY=1.
module tb_mem_lane_responder;

  localparam int LS  = 128;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          rd_i = 1'b0, wr_i = 1'b0;
  logic [31:0]   addr_i = 32'd0;
  logic [LS-1:0] wr_data_i = '0;
  logic          ready_o, rdy_o;
  logic [LS-1:0] rd_data_o;

  logic          f_rd_i = 1'b0, f_wr_i = 1'b0;
  logic [31:0]   f_addr_i = 32'd0;
  logic [LS-1:0] f_wr_data_i = '0;
  logic          f_ready_o, f_rdy_o;
  logic [LS-1:0] f_rd_data_o;

  int checks = 0;
  int passes = 0;

  logic [LS-1:0] model_mem [256];
  bit            written [256];
  logic [LS-1:0] last_rd = '0;
  int            wq[$];

  always #5 clk = ~clk;

  mem_lane_responder #(.MEM_LATENCY(LAT), .MEM_LANES(256), .LANE_SIZE(LS)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .rd_i(rd_i), .wr_i(wr_i), .addr_i(addr_i),
    .wr_data_i(wr_data_i), .ready_o(ready_o), .rdy_o(rdy_o), .rd_data_o(rd_data_o)
  );

  mem_lane_responder #(.MEM_LATENCY(1), .MEM_LANES(256), .LANE_SIZE(LS)) u_fast (
    .clk_i(clk), .rst_i(rst_i), .rd_i(f_rd_i), .wr_i(f_wr_i), .addr_i(f_addr_i),
    .wr_data_i(f_wr_data_i), .ready_o(f_ready_o), .rdy_o(f_rdy_o), .rd_data_o(f_rd_data_o)
  );

  function automatic int lane_of(input logic [31:0] a);
    return int'((a >> 4) % 32'd256);
  endfunction

  function automatic logic [LS-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [LS-1:0] obs, input logic [LS-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One complete request on the latency-4 instance, checked against the model.
  task automatic txn(input bit w, input bit r, input logic [31:0] a,
                     input logic [LS-1:0] d, input bit toggle);
    int  n;
    bit  seen;
    int  l;
    l = lane_of(a);
    chk("ready_before_req", LS'(ready_o), LS'(1'b1));
    wr_i = w; rd_i = r; addr_i = a; wr_data_i = d;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (rdy_o) begin
        seen = 1'b1;
      end else begin
        chk("ready_low_while_busy", LS'(ready_o), LS'(1'b0));
        if (toggle) begin
          addr_i    = $urandom;
          wr_data_i = rnd128();
        end
      end
    end
    chk("latency", LS'(n), LS'(LAT));
    if (w) begin
      model_mem[l] = d;
      if (!written[l]) wq.push_back(l);
      written[l] = 1'b1;
      chk("rd_data_hold", rd_data_o, last_rd);
    end else if (written[l]) begin
      chk("rd_data", rd_data_o, model_mem[l]);
      last_rd = model_mem[l];
    end
    @(negedge clk);
    chk("no_reaccept_ready", LS'(ready_o), LS'(1'b1));
    chk("no_reaccept_rdy", LS'(rdy_o), LS'(1'b0));
    wr_i = 1'b0; rd_i = 1'b0;
  endtask

  initial begin
    logic [LS-1:0] d;
    logic [31:0]   a;
    int            l;
    int            lane_pick;

    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("reset_ready", LS'(ready_o), LS'(1'b1));
    chk("reset_rdy", LS'(rdy_o), LS'(1'b0));
    chk("reset_rd_data", rd_data_o, '0);

    // Write then read the same lane.
    d = LS'(128'h0123);
    txn(1'b1, 1'b0, 32'h0000_0040, d, 1'b0);
    txn(1'b0, 1'b1, 32'h0000_0040, '0, 1'b0);

    // Simultaneous read and write is a write only.
    d = rnd128();
    txn(1'b1, 1'b1, 32'h0000_0080, d, 1'b0);
    @(negedge clk);
    chk("single_rdy_after_rw", LS'(rdy_o), LS'(1'b0));
    txn(1'b0, 1'b1, 32'h0000_0080, '0, 1'b0);

    // Address wrap modulo 256 lanes.
    txn(1'b1, 1'b0, 32'h0000_0010, {4{32'hAAAA_AAAA}}, 1'b0);
    txn(1'b0, 1'b1, 32'h0000_1010, '0, 1'b0);

    // Reset during a write aborts it.
    txn(1'b1, 1'b0, 32'h0000_0020, {4{32'h5555_5555}}, 1'b0);
    wr_i = 1'b1; addr_i = 32'h0000_0020; wr_data_i = {4{32'hFFFF_FFFF}};
    @(negedge clk);
    chk("abort_busy1_rdy", LS'(rdy_o), LS'(1'b0));
    @(negedge clk);
    chk("abort_busy2_rdy", LS'(rdy_o), LS'(1'b0));
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0; wr_i = 1'b0;
    chk("abort_ready", LS'(ready_o), LS'(1'b1));
    chk("abort_rdy", LS'(rdy_o), LS'(1'b0));
    chk("abort_rd_data_cleared", rd_data_o, '0);
    last_rd = '0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_rdy", LS'(rdy_o), LS'(1'b0));
    end
    txn(1'b0, 1'b1, 32'h0000_0020, '0, 1'b0);

    // Inputs toggled while busy are ignored.
    d = rnd128();
    txn(1'b1, 1'b0, 32'h0000_0350, d, 1'b1);
    txn(1'b0, 1'b1, 32'h0000_0350, '0, 1'b1);

    // Randomized mix; reads target lanes already written, with random alias bits.
    for (int i = 0; i < 40; i++) begin
      if (wq.size() == 0 || ($urandom % 2) == 0) begin
        txn(1'b1, 1'($urandom % 2), $urandom, rnd128(), 1'($urandom % 2));
      end else begin
        lane_pick = wq[$urandom_range(0, wq.size() - 1)];
        a = ($urandom & 32'hFFFF_F000) | (32'(lane_pick) << 4) | ($urandom & 32'h0000_000F);
        txn(1'b0, 1'b1, a, '0, 1'($urandom % 2));
      end
    end

    // Latency-1 instance: write, then hold a read continuously.
    d = rnd128();
    f_wr_i = 1'b1; f_addr_i = 32'h0000_0030; f_wr_data_i = d;
    @(negedge clk);
    chk("fast_wr_rdy", LS'(f_rdy_o), LS'(1'b1));
    @(negedge clk);
    chk("fast_wr_idle", LS'(f_ready_o), LS'(1'b1));
    f_wr_i = 1'b0;
    f_rd_i = 1'b1; f_wr_data_i = rnd128();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fast_rdy_alt", LS'(f_rdy_o), LS'((k % 2) == 0));
      chk("fast_ready_alt", LS'(f_ready_o), LS'((k % 2) != 0));
      if ((k % 2) == 0) chk("fast_rd_data", f_rd_data_o, d);
    end
    f_rd_i = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
